// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter.
// Holds the FSM state encodings, the master index constants and a
// helper that turns a master index into a one-hot grant vector.
package periph_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// One bus-master port of the peripheral bus arbiter.
//   req         master -> arbiter  request, held until ack
//   lock        master -> arbiter  keep the grant for the next transaction
//   periph_addr master -> arbiter  peripheral select (4 bits)
//   reg_addr    master -> arbiter  register select (4 bits)
//   rw          master -> arbiter  1 = write, 0 = read
//   wdata       master -> arbiter  write data
//   ack         arbiter -> master  one-cycle completion pulse
//   rdata       arbiter -> master  last read data, valid with ack
interface periph_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  lock;
  logic [3:0]            periph_addr;
  logic [3:0]            reg_addr;
  logic                  rw;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, lock, periph_addr, reg_addr, rw, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, lock, periph_addr, reg_addr, rw, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/periph_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req        requests, bit i = master i
//   rr_ptr     master favoured when both request
//   lock_valid a burst lock is active
//   lock_owner master holding the lock
//   gnt        one-hot winner, 00 when nobody requests
// A live lock whose owner is still requesting overrides round-robin; a lock
// whose owner has gone quiet falls through to normal arbitration.
module rr_arbiter2
  import periph_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_valid && req[lock_owner]) begin
      gnt = onehot2(lock_owner);
    end else if (req == 2'b11) begin
      gnt = onehot2(rr_ptr);
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the peripheral-controller access port between two masters
// (m0 = CPU load/store, m1 = DMA). Round-robin arbitration with an optional
// bounded burst lock; each transaction is a fixed ACCESS_CYCLES ce window
// followed by a one-cycle ack carrying registered read data.
//   clk, rst          clock, asynchronous active-low reset
//   m0, m1            master ports (periph_bus_arbiter_if.slave)
//   bus_*             controller access port (addr, rw, ce, wdata / rdata)
//   grant             one-hot current owner, 00 when idle
//   busy              high in ACCESS and ACK
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 1,
  parameter int MAX_BURST     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_bus_arbiter_if.slave   m0,
  periph_bus_arbiter_if.slave   m1,
  output logic [3:0]            bus_periph_addr,
  output logic [3:0]            bus_reg_addr,
  output logic                  bus_rw,
  output logic                  bus_ce,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [BC_W-1:0]       burst_cnt;
  logic                  rr_ptr;
  logic                  lock_valid;
  logic                  owner;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [3:0]            periph_q;
  logic [3:0]            reg_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [1:0]            req_vec;
  logic [1:0]            pick;
  logic                  owner_lock;
  logic                  in_access;

  assign req_vec    = {m1.req, m0.req};
  assign owner_lock = (owner == M1) ? m1.lock : m0.lock;

  rr_arbiter2 u_rr (
    .req        (req_vec),
    .rr_ptr     (rr_ptr),
    .lock_valid (lock_valid),
    .lock_owner (owner),
    .gnt        (pick)
  );

  // Control state: FSM, counters, arbitration history, read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      burst_cnt  <= '0;
      rr_ptr     <= M0;
      lock_valid <= 1'b0;
      owner      <= M0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Owner gave up its lock by not requesting: drop it; the arbiter
          // has already fallen through to a normal pick this cycle.
          if (lock_valid && !req_vec[owner]) begin
            lock_valid <= 1'b0;
            burst_cnt  <= '0;
          end
          if (pick != 2'b00) begin
            owner <= pick[1];
            cnt   <= CNT_LOAD;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!rw_q) rdata_q <= bus_rdata;
            state <= ST_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ACK: begin
          rr_ptr <= ~owner;
          if (owner_lock && (burst_cnt < BURST_LAST)) begin
            lock_valid <= 1'b1;
            burst_cnt  <= burst_cnt + BC_W'(1);
          end else begin
            lock_valid <= 1'b0;
            burst_cnt  <= '0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Transaction fields latched at grant; outputs are gated by state, so
  // these need no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && pick != 2'b00) begin
      periph_q <= pick[1] ? m1.periph_addr : m0.periph_addr;
      reg_q    <= pick[1] ? m1.reg_addr    : m0.reg_addr;
      rw_q     <= pick[1] ? m1.rw          : m0.rw;
      wdata_q  <= pick[1] ? m1.wdata       : m0.wdata;
    end
  end

  assign in_access       = (state == ST_ACCESS);
  assign bus_ce          = in_access;
  assign bus_periph_addr = in_access ? periph_q : 4'h0;
  assign bus_reg_addr    = in_access ? reg_q : 4'h0;
  assign bus_rw          = in_access & rw_q;
  assign bus_wdata       = (in_access && rw_q) ? wdata_q : '0;
  assign busy            = (state == ST_ACCESS) || (state == ST_ACK);
  assign grant           = busy ? onehot2(owner) : 2'b00;

  assign m0.ack   = (state == ST_ACK) && (owner == M0);
  assign m1.ack   = (state == ST_ACK) && (owner == M1);
  assign m0.rdata = rdata_q;
  assign m1.rdata = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: one DUT with ACCESS_CYCLES=1 and
// MAX_BURST=4, a second with ACCESS_CYCLES=3. Inputs change and outputs are
// sampled on the falling edge.
module tb_periph_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  periph_bus_arbiter_if #(.DATA_WIDTH(32)) m0_if ();
  periph_bus_arbiter_if #(.DATA_WIDTH(32)) m1_if ();
  periph_bus_arbiter_if #(.DATA_WIDTH(32)) m0_if3 ();
  periph_bus_arbiter_if #(.DATA_WIDTH(32)) m1_if3 ();

  logic [3:0]  bus_periph_addr, bus_reg_addr, bus_periph_addr3, bus_reg_addr3;
  logic        bus_rw, bus_ce, busy, bus_rw3, bus_ce3, busy3;
  logic [31:0] bus_wdata, bus_rdata, bus_wdata3, bus_rdata3;
  logic [1:0]  grant, grant3;

  periph_bus_arbiter #(.DATA_WIDTH(32), .ACCESS_CYCLES(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .bus_periph_addr(bus_periph_addr), .bus_reg_addr(bus_reg_addr),
    .bus_rw(bus_rw), .bus_ce(bus_ce), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .grant(grant), .busy(busy)
  );

  periph_bus_arbiter #(.DATA_WIDTH(32), .ACCESS_CYCLES(3), .MAX_BURST(4)) dut3 (
    .clk(clk), .rst(rst), .m0(m0_if3), .m1(m1_if3),
    .bus_periph_addr(bus_periph_addr3), .bus_reg_addr(bus_reg_addr3),
    .bus_rw(bus_rw3), .bus_ce(bus_ce3), .bus_wdata(bus_wdata3),
    .bus_rdata(bus_rdata3), .grant(grant3), .busy(busy3)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({bus_ce, bus_rw, bus_periph_addr, bus_reg_addr, grant, busy, m0_if.ack, m1_if.ack} !== 15'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0",
               {bus_ce, bus_rw, bus_periph_addr, bus_reg_addr, grant, busy, m0_if.ack, m1_if.ack});
    end
    checks++;
    if ({bus_wdata, m0_if.rdata, m1_if.rdata} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: wdata=%h m0_rdata=%h m1_rdata=%h expected 0",
               bus_wdata, m0_if.rdata, m1_if.rdata);
    end
    checks++;
    if ({bus_ce3, grant3, busy3, m0_if3.ack, m0_if3.rdata} !== 37'd0) begin
      errors++;
      $display("FAIL reset_dut3: got %h expected 0", {bus_ce3, grant3, busy3, m0_if3.ack, m0_if3.rdata});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    m0_if.req = 1'b1; m0_if.rw = 1'b0; m0_if.periph_addr = 4'h2; m0_if.reg_addr = 4'h0;
    m0_if.wdata = 32'hDEAD_BEEF; bus_rdata = 32'h0000_0005;
    step();
    checks++;
    if ({bus_ce, bus_rw, bus_periph_addr, bus_reg_addr, grant, busy, m0_if.ack} !== {1'b1, 1'b0, 4'h2, 4'h0, 2'b01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL read_access: ce=%b rw=%b pa=%h ra=%h grant=%b busy=%b ack=%b expected 1 0 2 0 01 1 0",
               bus_ce, bus_rw, bus_periph_addr, bus_reg_addr, grant, busy, m0_if.ack);
    end
    checks++;
    if (bus_wdata !== 32'd0) begin
      errors++; $display("FAIL read_wdata_masked: got %h expected 0", bus_wdata);
    end
    step();
    checks++;
    if ({m0_if.ack, m1_if.ack, bus_ce, grant} !== 5'b10001) begin
      errors++;
      $display("FAIL read_ack: m0_ack=%b m1_ack=%b ce=%b grant=%b expected 1 0 0 01",
               m0_if.ack, m1_if.ack, bus_ce, grant);
    end
    checks++;
    if (m0_if.rdata !== 32'd5) begin
      errors++; $display("FAIL read_rdata: got %h expected 5", m0_if.rdata);
    end
    m0_if.req = 1'b0; bus_rdata = 32'hAAAA_0000;
    step();
    checks++;
    if ({m0_if.ack, grant, busy, bus_ce} !== 5'd0 || m0_if.rdata !== 32'd5) begin
      errors++;
      $display("FAIL read_idle: ack=%b grant=%b busy=%b ce=%b rdata=%h expected 0 00 0 0 5",
               m0_if.ack, grant, busy, bus_ce, m0_if.rdata);
    end
  endtask

  task automatic test_single_write();
    m1_if.req = 1'b1; m1_if.rw = 1'b1; m1_if.periph_addr = 4'h1; m1_if.reg_addr = 4'h3;
    m1_if.wdata = 32'h0000_03E8; bus_rdata = 32'h0000_1234;
    step();
    checks++;
    if ({bus_ce, bus_rw, bus_periph_addr, bus_reg_addr, grant} !== {1'b1, 1'b1, 4'h1, 4'h3, 2'b10}) begin
      errors++;
      $display("FAIL write_access: ce=%b rw=%b pa=%h ra=%h grant=%b expected 1 1 1 3 10",
               bus_ce, bus_rw, bus_periph_addr, bus_reg_addr, grant);
    end
    checks++;
    if (bus_wdata !== 32'h0000_03E8) begin
      errors++; $display("FAIL write_wdata: got %h expected 3e8", bus_wdata);
    end
    step();
    checks++;
    if ({m1_if.ack, m0_if.ack, bus_ce} !== 3'b100 || m1_if.rdata !== 32'd5) begin
      errors++;
      $display("FAIL write_ack: m1_ack=%b m0_ack=%b ce=%b rdata=%h expected 1 0 0 5",
               m1_if.ack, m0_if.ack, bus_ce, m1_if.rdata);
    end
    m1_if.req = 1'b0;
    step();
    checks++;
    if (m1_if.ack !== 1'b0 || m1_if.rdata !== 32'd5) begin
      errors++; $display("FAIL write_idle: ack=%b rdata=%h expected 0 5", m1_if.ack, m1_if.rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    rst = 1'b0; step(); rst = 1'b1;
    m0_if.req = 1'b1; m0_if.rw = 1'b1; m0_if.wdata = 32'h0000_00A0;
    m1_if.req = 1'b1; m1_if.rw = 1'b1; m1_if.wdata = 32'h0000_00B1;
    for (int t = 0; t < 5; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      step();
      checks++;
      if (grant !== exp_g || bus_ce !== 1'b1 ||
          bus_wdata !== ((t % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1)) begin
        errors++;
        $display("FAIL cont_access[%0d]: grant=%b ce=%b wdata=%h expected grant %b ce 1", t, grant, bus_ce, bus_wdata, exp_g);
      end
      step();
      checks++;
      if ({m1_if.ack, m0_if.ack} !== exp_g || bus_ce !== 1'b0) begin
        errors++;
        $display("FAIL cont_ack[%0d]: acks=%b ce=%b expected %b 0", t, {m1_if.ack, m0_if.ack}, bus_ce, exp_g);
      end
      if (t == 3) m1_if.req = 1'b0;
      if (t == 4) m0_if.req = 1'b0;
      step();
      checks++;
      if ({m1_if.ack, m0_if.ack, bus_ce, grant} !== 5'd0) begin
        errors++;
        $display("FAIL cont_idle[%0d]: acks=%b ce=%b grant=%b expected 0", t, {m1_if.ack, m0_if.ack}, bus_ce, grant);
      end
    end
  endtask

  task automatic test_burst_lock();
    logic [1:0] exp_order [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [31:0] exp_wd;
    int m1_done = 0;
    int m0_done = 0;
    m1_if.req = 1'b1; m1_if.lock = 1'b1; m1_if.rw = 1'b1; m1_if.wdata = 32'd100;
    m0_if.rw = 1'b1; m0_if.lock = 1'b0; m0_if.wdata = 32'd200;
    for (int t = 0; t < 8; t++) begin
      exp_wd = (exp_order[t] == 2'b10) ? 32'(100 + m1_done) : 32'(200 + m0_done);
      step();
      if (t == 0) m0_if.req = 1'b1;
      checks++;
      if (grant !== exp_order[t] || bus_wdata !== exp_wd) begin
        errors++;
        $display("FAIL burst_grant[%0d]: grant=%b wdata=%0d expected %b %0d", t, grant, bus_wdata, exp_order[t], exp_wd);
      end
      step();
      checks++;
      if ({m1_if.ack, m0_if.ack} !== exp_order[t]) begin
        errors++;
        $display("FAIL burst_ack[%0d]: acks=%b expected %b", t, {m1_if.ack, m0_if.ack}, exp_order[t]);
      end
      if (exp_order[t] == 2'b10) begin
        m1_done++;
        if (m1_done == 6) begin
          m1_if.req = 1'b0; m1_if.lock = 1'b0;
          m0_if.req = 1'b1;
        end else begin
          m1_if.wdata = 32'(100 + m1_done);
        end
      end else begin
        m0_done++;
        m0_if.req = 1'b0; m0_if.wdata = 32'(200 + m0_done);
      end
      step();
    end
  endtask

  task automatic test_access3();
    m0_if3.req = 1'b1; m0_if3.rw = 1'b0; m0_if3.periph_addr = 4'h5; m0_if3.reg_addr = 4'h7;
    bus_rdata3 = 32'd0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({bus_ce3, bus_periph_addr3, bus_reg_addr3, m0_if3.ack, grant3} !== {1'b1, 4'h5, 4'h7, 1'b0, 2'b01}) begin
        errors++;
        $display("FAIL ac3_access[%0d]: ce=%b pa=%h ra=%h ack=%b grant=%b expected 1 5 7 0 01",
                 k, bus_ce3, bus_periph_addr3, bus_reg_addr3, m0_if3.ack, grant3);
      end
      bus_rdata3 = 32'(11 * k);
    end
    step();
    checks++;
    if ({bus_ce3, m0_if3.ack} !== 2'b01 || m0_if3.rdata !== 32'd33) begin
      errors++;
      $display("FAIL ac3_ack: ce=%b ack=%b rdata=%0d expected 0 1 33", bus_ce3, m0_if3.ack, m0_if3.rdata);
    end
    m0_if3.req = 1'b0; bus_rdata3 = 32'd99;
    step();
    checks++;
    if ({m0_if3.ack, busy3} !== 2'b00 || m0_if3.rdata !== 32'd33) begin
      errors++;
      $display("FAIL ac3_idle: ack=%b busy=%b rdata=%0d expected 0 0 33", m0_if3.ack, busy3, m0_if3.rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    // m0 read first so the pointer favours m1 before the reset
    m0_if.req = 1'b1; m0_if.rw = 1'b0; m0_if.periph_addr = 4'h0; bus_rdata = 32'd7;
    step(); step();
    checks++;
    if (m0_if.ack !== 1'b1 || m0_if.rdata !== 32'd7) begin
      errors++; $display("FAIL rst_pre_read: ack=%b rdata=%h expected 1 7", m0_if.ack, m0_if.rdata);
    end
    m0_if.rw = 1'b1; m0_if.wdata = 32'h55;
    step(); step();
    checks++;
    if (bus_ce !== 1'b1 || grant !== 2'b01) begin
      errors++; $display("FAIL rst_mid_access: ce=%b grant=%b expected 1 01", bus_ce, grant);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_ce, bus_rw, grant, busy, m0_if.ack, bus_wdata, m0_if.rdata} !== 70'd0) begin
      errors++;
      $display("FAIL rst_async_outputs: ce=%b rw=%b grant=%b busy=%b ack=%b wdata=%h rdata=%h expected 0",
               bus_ce, bus_rw, grant, busy, m0_if.ack, bus_wdata, m0_if.rdata);
    end
    step();
    rst = 1'b1; m0_if.req = 1'b0;
    step();
    checks++;
    if ({m0_if.ack, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_no_ack: ack=%b busy=%b expected 0 0", m0_if.ack, busy);
    end
    m0_if.req = 1'b1; m0_if.rw = 1'b0; m1_if.req = 1'b1; m1_if.rw = 1'b0;
    step();
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL rst_m0_favoured: grant=%b expected 01", grant);
    end
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_if.req = 0; m0_if.lock = 0; m0_if.periph_addr = 0; m0_if.reg_addr = 0; m0_if.rw = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.lock = 0; m1_if.periph_addr = 0; m1_if.reg_addr = 0; m1_if.rw = 0; m1_if.wdata = 0;
    m0_if3.req = 0; m0_if3.lock = 0; m0_if3.periph_addr = 0; m0_if3.reg_addr = 0; m0_if3.rw = 0; m0_if3.wdata = 0;
    m1_if3.req = 0; m1_if3.lock = 0; m1_if3.periph_addr = 0; m1_if3.reg_addr = 0; m1_if3.rw = 0; m1_if3.wdata = 0;
    bus_rdata = 0; bus_rdata3 = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_burst_lock();
    test_access3();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral-controller access port (periph/reg address, rw, ce, data) between two bus masters: m0 (CPU load/store path) and m1 (DMA engine, e.g. a future UART-TX DMA).
- Round-robin arbitration with an optional bounded burst lock.
- Sequences each transaction as a fixed-length ce window and returns a one-cycle ack with registered read data.
- Sits between the masters and peripheral_controller; no other block drives that controller's inputs.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ACCESS_CYCLES, 1, cycles bus_ce is held per transaction (>=1).
- MAX_BURST, 4, max consecutive locked grants to one master (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- m0_req  in  1  m0 transaction request, held until m0_ack.
- m0_lock  in  1  m0 requests to keep the grant for its next transaction.
- m0_periph_addr  in  4  m0 peripheral select.
- m0_reg_addr  in  4  m0 register select.
- m0_rw  in  1  m0 direction: 1 = write, 0 = read.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_ack  out  1  one-cycle completion pulse to m0.
- m0_rdata  out  DATA_WIDTH  read data, valid with m0_ack.
- m1_req, m1_lock, m1_periph_addr, m1_reg_addr, m1_rw, m1_wdata, m1_ack, m1_rdata: same widths and meaning as m0.
- bus_periph_addr  out  4  to controller periph_address.
- bus_reg_addr  out  4  to controller reg_address.
- bus_rw  out  1  to controller rw.
- bus_ce  out  1  to controller ce.
- bus_wdata  out  DATA_WIDTH  to controller data_in.
- bus_rdata  in  DATA_WIDTH  from controller data_out (may be z on writes).
- grant  out  2  one-hot current owner, 00 when idle.
- busy  out  1  high in ACCESS and ACK.

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-low.
- Reset (rst=0):
  - state=IDLE, rr_ptr=0 (m0 favoured), lock_valid=0, burst_cnt=0.
  - rdata_q=0, and every output is 0.
  - An in-flight transaction is abandoned with no ack.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Bus outputs are all 0 and grant=00.
  - If lock_valid: only the lock owner is considered.
    - Owner req=1: grant it.
    - Owner req=0: clear lock_valid and burst_cnt, then arbitrate normally in the same cycle.
  - Normal arbitration:
    - Only one req: grant it.
    - Both reqs: grant the master pointed to by rr_ptr.
  - On grant:
    - Latch the winner's addr, rw and wdata into internal registers.
    - Set grant one-hot, load cnt=ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - bus_ce=1; bus_periph_addr, bus_reg_addr, bus_rw and bus_wdata come from the latched registers.
  - bus_wdata is 0 when rw=0.
  - cnt decrements each cycle.
  - At cnt==0: if read, rdata_q <= bus_rdata; go to ACK.
  - Writes leave rdata_q unchanged.
  - Latency from req sampled in IDLE to ack high is ACCESS_CYCLES+1 cycles.
- ACK:
  - bus_ce=0; the winner's ack=1 for exactly this cycle; m0_rdata=m1_rdata=rdata_q.
  - rr_ptr <= other master.
  - Lock handling:
    - Winner lock=1 and burst_cnt < MAX_BURST-1: lock_valid=1, burst_cnt++.
    - Otherwise: lock_valid=0, burst_cnt=0.
  - Always return to IDLE.
- Handshake rules:
  - Masters hold req and fields stable until ack.
  - On the edge after ack, a master drops req or presents its next transaction.
  - The arbiter re-samples in IDLE, so back-to-back transactions cost 1 idle cycle each.
- The loser's req stays pending with no ack and no timeout.
- req deasserted while its transaction is in ACCESS is ignored; the transaction completes and acks.
- A burst reaching MAX_BURST forces release even if lock stays high. rr_ptr then favours the other master, which wins if requesting.
- MAX_BURST=1 means lock has no effect.
- m*_rdata holds the last read value between acks.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2) and the master index constants M0/M1.
- Peripheral address constants remain in the existing peripheral-address header.
- One natural sub-module, rr_arbiter2: a combinational 2-way round-robin pick from req[1:0], rr_ptr and lock mask, giving a one-hot grant.
- Counters and FSM stay in the top module.

Test Plan:
- Reset mid-ACCESS: m0 write, rst low during ACCESS -> no m0_ack, all outputs 0, next transaction after rst high starts from IDLE with m0 favoured.
- Single read, ACCESS_CYCLES=1: m0 read periph=4'h2 reg=4'h0, bus_rdata=32'h0000_0005 -> bus_ce high for 1 cycle with addr 2/0 and rw=0; m0_ack 2 cycles after req, with m0_rdata=5.
- Single write: m1 write periph=4'h1, wdata=32'h0000_03E8 -> bus_rw=1, bus_wdata=32'h3E8 for 1 cycle, m1_ack pulse, rdata unchanged.
- Contention: m0 and m1 request continuously from reset -> grant order m0, m1, m0, m1; each ack is exactly 1 cycle; no overlapping bus_ce.
- Burst lock, MAX_BURST=4: m1 lock=1 issues 6 writes while m0 requests -> 4 consecutive m1 grants, then m0, then m1's remaining 2.
- ACCESS_CYCLES=3, read: bus_ce high exactly 3 cycles; rdata captured from bus_rdata on the 3rd; ack on the 4th cycle after grant.
